alu_cmd_sequencer: RTL and testbench

//  Initiator side of the 8-bit ALU interface; it replaces the hand-stepped bench stimulus with hardware.

---
 rtl/alu_cmd_sequencer_pkg.sv | 30 +++
 rtl/alu_cmd_sequencer_if.sv | 45 ++++
 rtl/alu_8bit.sv | 29 ++
 rtl/alu_cmd_fifo.sv | 47 ++++
 rtl/alu_cmd_sequencer.sv | 106 ++++++++++
 tb/tb_alu_cmd_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Opcodes, command record layout and sequencer FSM states.
package alu_cmd_sequencer_pkg;

    localparam int ALU_W = 8;
    localparam int SEL_W = 3;
    localparam int CMD_W = 2 * ALU_W + SEL_W;

    localparam logic [SEL_W-1:0] ALU_ADD   = 3'b000;
    localparam logic [SEL_W-1:0] ALU_SUB   = 3'b001;
    localparam logic [SEL_W-1:0] ALU_AND   = 3'b010;
    localparam logic [SEL_W-1:0] ALU_OR    = 3'b011;
    localparam logic [SEL_W-1:0] ALU_XOR   = 3'b100;
    localparam logic [SEL_W-1:0] ALU_NOTA  = 3'b101;
    localparam logic [SEL_W-1:0] ALU_INCA  = 3'b110;
    localparam logic [SEL_W-1:0] ALU_CLEAR = 3'b111;

    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [SEL_W-1:0] sel;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-drive and response bundle of the sequencer.
// slave: sequencer side; master: command source / response sink.
interface alu_cmd_sequencer_if;
    import alu_cmd_sequencer_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [ALU_W-1:0] cmd_a;
    logic [ALU_W-1:0] cmd_b;
    logic [SEL_W-1:0] cmd_sel;

    logic [ALU_W-1:0] alu_a;
    logic [ALU_W-1:0] alu_b;
    logic [SEL_W-1:0] alu_sel;
    logic [ALU_W-1:0] alu_result;
    logic             alu_carry;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [ALU_W-1:0] rsp_result;
    logic             rsp_carry;
    logic             rsp_zero;
    logic [SEL_W-1:0] rsp_sel;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel,
        output cmd_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_result, alu_carry,
        output rsp_valid, rsp_result, rsp_carry,
        output rsp_zero, rsp_sel,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel,
        input  cmd_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_result, alu_carry,
        input  rsp_valid, rsp_result, rsp_carry,
        input  rsp_zero, rsp_sel,
        output rsp_ready
    );

endinterface

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU driven by the sequencer.
// Ports: a, b, sel in; result, carry out (SUB carry = borrow).
module alu_8bit
    import alu_cmd_sequencer_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [SEL_W-1:0] sel,
    output logic [ALU_W-1:0] result,
    output logic             carry
);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        unique case (sel)
            ALU_ADD:   {carry, result} = {1'b0, a} + {1'b0, b};
            ALU_SUB:   {carry, result} = {1'b0, a} - {1'b0, b};
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_NOTA:  result = ~a;
            ALU_INCA:  {carry, result} = {1'b0, a} + 9'd1;
            ALU_CLEAR: result = '0;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO, power-of-2 depth, show-ahead read.
// Ports: push, pop, wdata in; rdata, full, empty out.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;
    logic         do_push;
    logic         do_pop;

    // Extra pointer bit tells full from empty when indices match.
    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) &&
                     (wp[AW-1:0] == rp[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, drives them to the ALU, returns results.
// Ports: clk, rst, bus (slave), op_count (completed responses).
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_cmd_sequencer_if.slave   bus,
    output logic [15:0]          op_count
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);

    state_e        state;
    logic [CW-1:0] cnt;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    alu_cmd_t      wcmd;
    alu_cmd_t      head;

    assign bus.cmd_ready = !full;
    assign push = bus.cmd_valid && !full;
    assign wcmd = '{a: bus.cmd_a, b: bus.cmd_b, sel: bus.cmd_sel};

    // Pop when idle, or when the pending response is taken.
    assign pop = !empty &&
                 ((state == S_IDLE) ||
                  ((state == S_RESP) && bus.rsp_ready));

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wcmd),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.alu_sel    <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_carry  <= 1'b0;
            bus.rsp_zero   <= 1'b0;
            bus.rsp_sel    <= '0;
            op_count       <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        bus.alu_a   <= head.a;
                        bus.alu_b   <= head.b;
                        bus.alu_sel <= head.sel;
                        cnt         <= CNT_INIT;
                        state       <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (cnt == '0) begin
                        bus.rsp_result <= bus.alu_result;
                        bus.rsp_carry  <= bus.alu_carry;
                        bus.rsp_zero   <= (bus.alu_result == '0);
                        bus.rsp_sel    <= bus.alu_sel;
                        bus.rsp_valid  <= 1'b1;
                        state          <= S_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        op_count      <= op_count + 16'd1;
                        bus.rsp_valid <= 1'b0;
                        if (pop) begin
                            bus.alu_a   <= head.a;
                            bus.alu_b   <= head.b;
                            bus.alu_sel <= head.sel;
                            cnt         <= CNT_INIT;
                            state       <= S_DRIVE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with alu_8bit attached.
// Table vectors, hand sequences and a random run against a scoreboard.
module tb_alu_cmd_sequencer;
    import alu_cmd_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] op_count0;
    logic [15:0] op_count1;

    int checks = 0;
    int passes = 0;

    alu_cmd_sequencer_if if0 ();
    alu_cmd_sequencer_if if1 ();

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.FIFO_DEPTH(4), .SETTLE(1)) u0 (
        .clk      (clk),
        .rst      (rst),
        .bus      (if0.slave),
        .op_count (op_count0)
    );

    alu_cmd_sequencer #(.FIFO_DEPTH(4), .SETTLE(3)) u1 (
        .clk      (clk),
        .rst      (rst),
        .bus      (if1.slave),
        .op_count (op_count1)
    );

    alu_8bit alu0 (
        .a      (if0.alu_a),
        .b      (if0.alu_b),
        .sel    (if0.alu_sel),
        .result (if0.alu_result),
        .carry  (if0.alu_carry)
    );

    alu_8bit alu1 (
        .a      (if1.alu_a),
        .b      (if1.alu_b),
        .sel    (if1.alu_sel),
        .result (if1.alu_result),
        .carry  (if1.alu_carry)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sel;
        logic [7:0] res;
        logic       carry;
        logic       zero;
    } vec_t;

    vec_t vt [9];

    // Scoreboard of accepted commands and log of responses.
    alu_cmd_t     sb [$];
    logic [12:0]  rsp_log [$];
    logic [15:0]  mcnt = '0;

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic fail(input string name);
        checks++;
        $display("FAIL %s: timed out", name);
    endtask

    // Reference ALU from the opcode definitions, plain integer math.
    function automatic logic [8:0] ref_alu(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [2:0] sel);
        int ia = int'(a);
        int ib = int'(b);
        int r  = 0;
        logic c = 1'b0;
        case (sel)
            3'd0: begin r = ia + ib; c = (r > 255); end
            3'd1: begin r = ia - ib; c = (ia < ib); end
            3'd2: r = int'(a & b);
            3'd3: r = int'(a | b);
            3'd4: r = int'(a ^ b);
            3'd5: r = 255 - ia;
            3'd6: begin r = ia + 1; c = (r > 255); end
            default: r = 0;
        endcase
        r = r & 255;
        return {c, 8'(r)};
    endfunction

    // Monitor for u0: scoreboard, count and hold checks.
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic        have_prev = 1'b0;
    logic [12:0] pbundle = '0;

    always @(negedge clk) begin
        alu_cmd_t    c;
        logic [8:0]  e;
        logic [12:0] cur;
        cur = {if0.rsp_sel, if0.rsp_zero, if0.rsp_carry,
               if0.rsp_result};
        if (rst) begin
            sb.delete();
            mcnt = '0;
            have_prev = 1'b0;
        end else begin
            if (have_prev && pv && !pr) begin
                check("rsp_hold", {18'd0, if0.rsp_valid, cur},
                      {18'd0, 1'b1, pbundle});
            end
            if (if0.cmd_valid && if0.cmd_ready)
                sb.push_back('{a: if0.cmd_a, b: if0.cmd_b,
                               sel: if0.cmd_sel});
            if (if0.rsp_valid && if0.rsp_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_rsp", 32'd1, 32'd0);
                end else begin
                    c = sb.pop_front();
                    e = ref_alu(c.a, c.b, c.sel);
                    check("rsp_vs_model", {19'd0, cur},
                          {19'd0, c.sel, (e[7:0] == 8'h00),
                           e[8], e[7:0]});
                end
                check("op_count", {16'd0, op_count0}, {16'd0, mcnt});
                mcnt = mcnt + 16'd1;
                rsp_log.push_back(cur);
            end
            pv = if0.rsp_valid;
            pr = if0.rsp_ready;
            pbundle = cur;
            have_prev = 1'b1;
        end
    end

    // Called at posedge+1; returns at posedge+1 after acceptance.
    task automatic push(input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] sel);
        int n = 0;
        if0.cmd_valid = 1'b1;
        if0.cmd_a = a;
        if0.cmd_b = b;
        if0.cmd_sel = sel;
        forever begin
            @(negedge clk);
            if (if0.cmd_ready) break;
            n++;
            if (n > 200) begin
                fail("push");
                break;
            end
        end
        @(posedge clk); #1;
        if0.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        forever begin
            @(negedge clk);
            if (sb.size() == 0 && !if0.rsp_valid) break;
            n++;
            if (n > 2000) begin
                fail("drain");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp();
        int n = 0;
        forever begin
            @(negedge clk);
            if (if0.rsp_valid) break;
            n++;
            if (n > 50) begin
                fail("wait_rsp");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // Single command into an idle sequencer; watch rsp_valid rise.
    task automatic latency(input int which, input int s);
        logic [7:0] a;
        a = 8'h33 + 8'(which);
        if (which == 0) begin
            if0.cmd_valid = 1'b1; if0.cmd_a = a;
            if0.cmd_b = 8'h11; if0.cmd_sel = ALU_ADD;
        end else begin
            if1.cmd_valid = 1'b1; if1.cmd_a = a;
            if1.cmd_b = 8'h11; if1.cmd_sel = ALU_ADD;
        end
        @(posedge clk); #1;
        if0.cmd_valid = 1'b0;
        if1.cmd_valid = 1'b0;
        for (int k = 1; k <= s + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (which == 0) begin
                check("lat_valid0", {31'd0, if0.rsp_valid},
                      {31'd0, (k == s + 1)});
                if (k == 1) check("lat_alu_a0", {24'd0, if0.alu_a},
                                  {24'd0, a});
                if (k == s + 1)
                    check("lat_res0", {24'd0, if0.rsp_result},
                          {24'd0, a + 8'h11});
            end else begin
                check("lat_valid1", {31'd0, if1.rsp_valid},
                      {31'd0, (k == s + 1)});
                if (k == 1) check("lat_alu_a1", {24'd0, if1.alu_a},
                                  {24'd0, a});
                if (k == s + 1)
                    check("lat_res1", {24'd0, if1.rsp_result},
                          {24'd0, a + 8'h11});
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0] = '{8'd10, 8'd5, ALU_ADD,   8'h0F, 1'b0, 1'b0};
        vt[1] = '{8'd10, 8'd5, ALU_SUB,   8'h05, 1'b0, 1'b0};
        vt[2] = '{8'd10, 8'd5, ALU_AND,   8'h00, 1'b0, 1'b1};
        vt[3] = '{8'd10, 8'd5, ALU_OR,    8'h0F, 1'b0, 1'b0};
        vt[4] = '{8'd10, 8'd5, ALU_XOR,   8'h0F, 1'b0, 1'b0};
        vt[5] = '{8'd10, 8'd5, ALU_NOTA,  8'hF5, 1'b0, 1'b0};
        vt[6] = '{8'd10, 8'd5, ALU_INCA,  8'h0B, 1'b0, 1'b0};
        vt[7] = '{8'd10, 8'd5, ALU_CLEAR, 8'h00, 1'b0, 1'b1};
        vt[8] = '{8'd200, 8'd100, ALU_ADD, 8'h2C, 1'b1, 1'b0};

        if0.cmd_valid = 1'b0; if0.cmd_a = '0;
        if0.cmd_b = '0; if0.cmd_sel = '0; if0.rsp_ready = 1'b1;
        if1.cmd_valid = 1'b0; if1.cmd_a = '0;
        if1.cmd_b = '0; if1.cmd_sel = '0; if1.rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_rsp_valid", {31'd0, if0.rsp_valid}, 32'd0);
        check("rst_cmd_ready", {31'd0, if0.cmd_ready}, 32'd1);
        check("rst_op_count", {16'd0, op_count0}, 32'd0);
        check("rst_alu_a", {24'd0, if0.alu_a}, 32'd0);
        check("rst_rsp_result", {24'd0, if0.rsp_result}, 32'd0);
        @(posedge clk); #1;

        // Opcode sweep, back-to-back
        rsp_log.delete();
        for (int i = 0; i < 8; i++) push(vt[i].a, vt[i].b, vt[i].sel);
        drain();
        check("sweep_op_count", {16'd0, op_count0}, 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (rsp_log.size() > i)
                check("sweep_vec", {19'd0, rsp_log[i]},
                      {19'd0, vt[i].sel, vt[i].zero, vt[i].carry,
                       vt[i].res});
            else
                fail("sweep_missing");
        end

        // Carry out of ADD
        rsp_log.delete();
        push(vt[8].a, vt[8].b, vt[8].sel);
        drain();
        if (rsp_log.size() == 1)
            check("carry_vec", {19'd0, rsp_log[0]},
                  {19'd0, vt[8].sel, vt[8].zero, vt[8].carry,
                   vt[8].res});
        else
            fail("carry_missing");

        // Backpressure: fill the queue behind a stalled response
        if0.rsp_ready = 1'b0;
        push(8'h01, 8'h02, ALU_SUB);
        wait_rsp();
        for (int i = 0; i < 4; i++)
            push(8'($urandom), 8'($urandom), 3'($urandom));
        @(negedge clk);
        check("bp_full", {31'd0, if0.cmd_ready}, 32'd0);
        repeat (10) @(negedge clk);
        check("bp_held", {31'd0, if0.rsp_valid}, 32'd1);
        @(posedge clk); #1;
        if0.rsp_ready = 1'b1;
        push(8'hF0, 8'h0F, ALU_XOR);
        drain();

        // Latency for SETTLE=1 and SETTLE=3
        latency(0, 1);
        drain();
        latency(1, 3);
        check("lat_count1", {16'd0, op_count1}, 32'd1);

        // Reset while a command is in DRIVE with three queued
        if0.rsp_ready = 1'b0;
        push(8'h11, 8'h22, ALU_OR);
        wait_rsp();
        for (int i = 0; i < 4; i++)
            push(8'(i + 1), 8'h40, ALU_ADD);
        if0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        if0.rsp_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", {31'd0, if0.rsp_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, if0.cmd_ready}, 32'd1);
        check("mid_rst_count", {16'd0, op_count0}, 32'd0);
        @(posedge clk); #1;
        if0.rsp_ready = 1'b1;
        rsp_log.delete();
        push(8'd7, 8'd9, ALU_ADD);
        drain();
        if (rsp_log.size() == 1)
            check("post_rst_res", {19'd0, rsp_log[0]},
                  {19'd0, ALU_ADD, 1'b0, 1'b0, 8'h10});
        else
            fail("post_rst_missing");

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            if0.cmd_valid = ($urandom_range(0, 1) == 1);
            if0.cmd_a = 8'($urandom);
            if0.cmd_b = 8'($urandom);
            if0.cmd_sel = 3'($urandom);
            if0.rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        if0.cmd_valid = 1'b0;
        if0.rsp_ready = 1'b1;
        drain();

        // Counter wrap
        @(negedge clk);
        force u0.op_count = 16'hFFFF;
        #1;
        release u0.op_count;
        mcnt = 16'hFFFF;
        @(posedge clk); #1;
        push(8'h05, 8'h03, ALU_AND);
        drain();
        check("wrap_count", {16'd0, op_count0}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
